// File: rtl/seg_scan_display.sv
// Time-multiplexed seven-segment scanner with glyph decode, blink/DP masks,
// inter-digit dead time and a saturating thermometer LED bar.
module seg_scan_display #(
    parameter int unsigned DIGITS      = 8,
    parameter int unsigned SCAN_DIV    = 12500,
    parameter int unsigned BLINK_TICKS = 25,
    parameter int unsigned BAR_W       = 10
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic [5*DIGITS-1:0]            DIGIT_DATA,
    input  logic [DIGITS-1:0]              DIGIT_EN,
    input  logic [DIGITS-1:0]              BLINK_MASK,
    input  logic [DIGITS-1:0]              DP_MASK,
    input  logic [$clog2(BAR_W+1)-1:0]     BAR_LEVEL,
    input  logic                           BAR_BLINK,
    output logic [DIGITS-1:0]              AN,
    output logic [7:0]                     SEG,
    output logic [BAR_W-1:0]               LED
);

    localparam int unsigned PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned DW = $clog2(SCAN_DIV);
    localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [DW-1:0]         presc;
    logic [PW-1:0]         ptr;
    logic [PW-1:0]         ptr_nxt;
    logic [PW-1:0]         cand;
    logic                  found;
    logic                  active;
    logic                  phase;
    logic [BW-1:0]         bcnt;
    logic                  tick;
    logic [5*DIGITS-1:0]   data_sh;
    logic [4:0]            glyph;
    logic [7:0]            seg_live;
    logic [BAR_W-1:0]      therm;

    function automatic logic [7:0] decode(input logic [4:0] code);
        logic [7:0] s;
        case (code)
            5'd0:    s = 8'h03;
            5'd1:    s = 8'h9F;
            5'd2:    s = 8'h25;
            5'd3:    s = 8'h0D;
            5'd4:    s = 8'h99;
            5'd5:    s = 8'h49;
            5'd6:    s = 8'h41;
            5'd7:    s = 8'h1F;
            5'd8:    s = 8'h01;
            5'd9:    s = 8'h09;
            5'd10:   s = 8'h11;
            5'd11:   s = 8'hC1;
            5'd12:   s = 8'h63;
            5'd13:   s = 8'h85;
            5'd14:   s = 8'h61;
            5'd15:   s = 8'h71;
            5'd17:   s = 8'hEF;
            5'd18:   s = 8'h91;
            5'd19:   s = 8'hE3;
            5'd20:   s = 8'hF5;
            5'd21:   s = 8'hFD;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    assign tick = (presc == DW'(SCAN_DIV - 1));

    // Circular search starting just after ptr; a full lap lands back on ptr,
    // so a lone enabled digit keeps the pointer and no enabled digit holds it.
    always_comb begin
        ptr_nxt = ptr;
        cand    = ptr;
        found   = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            cand = (cand == PW'(DIGITS - 1)) ? '0 : cand + 1'b1;
            if (!found && DIGIT_EN[cand]) begin
                ptr_nxt = cand;
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        data_sh  = DIGIT_DATA >> (5 * ptr);
        glyph    = data_sh[4:0];
        seg_live = decode(glyph);
        if (DP_MASK[ptr])
            seg_live[0] = 1'b0;
        if (phase && BLINK_MASK[ptr])
            seg_live = '1;
    end

    always_comb begin
        if (32'(BAR_LEVEL) >= BAR_W)
            therm = '1;
        else
            therm = (BAR_W'(1) << BAR_LEVEL) - 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            presc  <= '0;
            ptr    <= PW'(DIGITS - 1);
            active <= 1'b0;
            phase  <= 1'b0;
            bcnt   <= '0;
            AN     <= '1;
            SEG    <= 8'hFF;
            LED    <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                // DIGIT_EN is only sampled here; the cycle after a tick is dead time.
                ptr    <= ptr_nxt;
                active <= |DIGIT_EN;
                AN     <= '1;
                SEG    <= 8'hFF;
                if (bcnt == BW'(BLINK_TICKS - 1)) begin
                    bcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    bcnt <= bcnt + 1'b1;
                end
            end else begin
                AN  <= active ? ~(DIGITS'(1) << ptr) : '1;
                SEG <= active ? seg_live : 8'hFF;
            end
            LED <= (phase && BAR_BLINK) ? '0 : therm;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with DIGITS=8, SCAN_DIV=4,
// BLINK_TICKS=2, BAR_W=10; cycle 0 is the first cycle with RST_N high.
module tb_seg_scan_display;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [39:0] DIGIT_DATA;
    logic [7:0]  DIGIT_EN;
    logic [7:0]  BLINK_MASK;
    logic [7:0]  DP_MASK;
    logic [3:0]  BAR_LEVEL;
    logic        BAR_BLINK;
    logic [7:0]  AN;
    logic [7:0]  SEG;
    logic [9:0]  LED;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    seg_scan_display #(
        .DIGITS(8),
        .SCAN_DIV(4),
        .BLINK_TICKS(2),
        .BAR_W(10)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .DIGIT_DATA(DIGIT_DATA),
        .DIGIT_EN(DIGIT_EN),
        .BLINK_MASK(BLINK_MASK),
        .DP_MASK(DP_MASK),
        .BAR_LEVEL(BAR_LEVEL),
        .BAR_BLINK(BAR_BLINK),
        .AN(AN),
        .SEG(SEG),
        .LED(LED)
    );

    always #5 CLK = ~CLK;

    logic [7:0] exp_an  [24] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                 8'hFE, 8'hFE, 8'hFE, 8'hFF,
                                 8'hFD, 8'hFD, 8'hFD, 8'hFF,
                                 8'hFB, 8'hFB, 8'hFB, 8'hFF,
                                 8'hF7, 8'hF7, 8'hF7, 8'hFF,
                                 8'hFE, 8'hFE, 8'hFE};
    logic [7:0] exp_seg [24] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                 8'h9F, 8'h9F, 8'h9F, 8'hFF,
                                 8'h25, 8'h25, 8'h25, 8'hFF,
                                 8'h0D, 8'h0D, 8'h0D, 8'hFF,
                                 8'h99, 8'h99, 8'h99, 8'hFF,
                                 8'h9F, 8'h9F, 8'h9F};
    logic [7:0] glyph_tab [32] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                   8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71,
                                   8'hFF, 8'hEF, 8'h91, 8'hE3, 8'hF5, 8'hFD, 8'hFF, 8'hFF,
                                   8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [3:0] lvl_tab  [6] = '{4'd0, 4'd3, 4'd10, 4'd15, 4'd9, 4'd1};
    logic [9:0] led_tab  [6] = '{10'h000, 10'h007, 10'h3FF, 10'h3FF, 10'h1FF, 10'h001};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic to_cycle(input int n);
        while (cyc < n) begin
            @(negedge CLK);
            cyc++;
        end
    endtask

    task automatic set_code(input int i, input logic [4:0] code);
        DIGIT_DATA[5*i +: 5] = code;
    endtask

    // Three reset edges, release right after a rising edge, park at cycle 0's negedge.
    task automatic do_reset();
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        @(negedge CLK);
        cyc = 0;
    endtask

    initial begin
        int t;
        RST_N      = 1'b0;
        DIGIT_DATA = '0;
        DIGIT_EN   = 8'h0F;
        BLINK_MASK = 8'h00;
        DP_MASK    = 8'h00;
        BAR_LEVEL  = 4'd3;
        BAR_BLINK  = 1'b0;
        set_code(0, 5'd1);
        set_code(1, 5'd2);
        set_code(2, 5'd3);
        set_code(3, 5'd4);

        // Reset state and first scan sequence
        @(negedge CLK);
        check("rst_an", AN, 8'hFF);
        check("rst_seg", SEG, 8'hFF);
        check("rst_led", LED, 10'h000);
        do_reset();
        check("t1_led_c0", LED, 10'h000);
        for (int k = 0; k < 24; k++) begin
            to_cycle(k);
            check("t1_an", AN, exp_an[k]);
            check("t1_seg", SEG, exp_seg[k]);
            if (k == 1) check("t1_led_c1", LED, 10'h007);
        end

        // Sparse enable, wrap from digit 7, then disable all mid-slot
        DIGIT_EN  = 8'b1000_0101;
        BAR_LEVEL = 4'd0;
        set_code(0, 5'd0);
        set_code(2, 5'd2);
        set_code(7, 5'd7);
        do_reset();
        to_cycle(5);  check("t2_an_d0", AN, 8'hFE);
        to_cycle(8);  check("t2_dead", AN, 8'hFF);
        to_cycle(9);  check("t2_an_d2", AN, 8'hFB); check("t2_seg_d2", SEG, 8'h25);
        to_cycle(13); check("t2_an_d7", AN, 8'h7F); check("t2_seg_d7", SEG, 8'h1F);
        to_cycle(17); check("t2_an_wrap", AN, 8'hFE); check("t2_seg_wrap", SEG, 8'h03);
        to_cycle(18); DIGIT_EN = 8'h00;
        to_cycle(19); check("t2_slot_done", AN, 8'hFE);
        to_cycle(20); check("t2_off_an", AN, 8'hFF); check("t2_off_seg", SEG, 8'hFF);
        to_cycle(23); check("t2_off_an2", AN, 8'hFF);
        to_cycle(27); check("t2_off_an3", AN, 8'hFF); check("t2_off_seg3", SEG, 8'hFF);

        // Glyph sweep on a lone enabled digit, DP, then LED levels
        DIGIT_EN = 8'h01;
        set_code(0, 5'd0);
        do_reset();
        t = 4;
        for (int code = 0; code < 32; code++) begin
            t = t + 1;
            while (((t - 4) % 4) == 0) t = t + 1;
            to_cycle(t - 1);
            set_code(0, 5'(code));
            to_cycle(t);
            check("t3_glyph", SEG, glyph_tab[code]);
            check("t3_an_hold", AN, 8'hFE);
        end
        t = t + 1;
        while (((t - 4) % 4) == 0) t = t + 1;
        to_cycle(t - 1); set_code(0, 5'd8); DP_MASK = 8'h01;
        to_cycle(t);     check("t3_dp_8", SEG, 8'h00);
        t = t + 1;
        while (((t - 4) % 4) == 0) t = t + 1;
        to_cycle(t - 1); set_code(0, 5'd16);
        to_cycle(t);     check("t3_dp_blank", SEG, 8'hFE);
        t = t + 1;
        while (((t - 4) % 4) == 0) t = t + 1;
        to_cycle(t - 1); set_code(0, 5'd3);
        to_cycle(t);     check("t3_dp_3", SEG, 8'h0C);
        DP_MASK = 8'h00;
        BAR_LEVEL = 4'd0;
        t = t + 2;
        to_cycle(t);
        check("t5_led_init", LED, 10'h000);
        for (int i = 1; i < 6; i++) begin
            BAR_LEVEL = lvl_tab[i];
            to_cycle(t + 1);
            check("t5_led_new", LED, led_tab[i]);
            to_cycle(t + 2);
            t = t + 2;
        end

        // Blink on digit 0 with two digits scanning, bar blinking
        DIGIT_EN   = 8'h03;
        BLINK_MASK = 8'h01;
        BAR_LEVEL  = 4'd10;
        BAR_BLINK  = 1'b1;
        set_code(0, 5'd0);
        set_code(1, 5'd1);
        do_reset();
        to_cycle(6);  check("t4_d0_on", SEG, 8'h03); check("t4_an_d0", AN, 8'hFE);
        to_cycle(8);  check("t4_led_on", LED, 10'h3FF);
        to_cycle(9);  check("t4_led_off", LED, 10'h000);
        to_cycle(10); check("t4_d1", SEG, 8'h9F); check("t4_an_d1", AN, 8'hFD);
        to_cycle(14); check("t4_d0_off", SEG, 8'hFF); check("t4_an_kept", AN, 8'hFE);
        to_cycle(16); check("t4_led_off2", LED, 10'h000);
        to_cycle(17); check("t4_led_on2", LED, 10'h3FF);
        to_cycle(18); check("t4_d1_b", SEG, 8'h9F);
        to_cycle(22); check("t4_d0_on2", SEG, 8'h03);
        to_cycle(24); BAR_BLINK = 1'b0;

        // Reset asserted during a driven cycle of digit 1
        to_cycle(26);
        check("t6_pre_an", AN, 8'hFD);
        check("t6_pre_seg", SEG, 8'h9F);
        check("t6_pre_led", LED, 10'h3FF);
        RST_N = 1'b0;
        to_cycle(27);
        check("t6_rst_an", AN, 8'hFF);
        check("t6_rst_seg", SEG, 8'hFF);
        check("t6_rst_led", LED, 10'h000);
        do_reset();
        to_cycle(4); check("t6_dead_an", AN, 8'hFF);
        to_cycle(5); check("t6_restart_an", AN, 8'hFE); check("t6_restart_seg", SEG, 8'h03);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
